// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int STEPS = 32;

endpackage

// File: rtl/muldiv_signfix.sv
// Final sign correction and result selection applied in the FIX cycle.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  muldiv_op_t         op,
    input  logic               neg,
    input  logic [2*WIDTH-1:0] acc,
    output logic [WIDTH-1:0]   result
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // acc holds the full product for multiplies, {remainder, quotient} for divides
    always_comb begin
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        case (op)
            OP_MUL:                       result = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              result = quo;
            default:                      result = rem;
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, 32 steps.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one shift-add / trial-subtract step per cycle, counter runs down to 0
// FIX   | sign correction and result select, out is loaded on exit
// DONE  | done pulse, out valid, a new start may be accepted
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] arg1,
    input  logic [WIDTH-1:0] arg2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_nxt;
    muldiv_op_t         op_in;
    muldiv_op_t         op_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd;
    logic               neg_q;

    logic               accept;
    logic               is_mul_in;
    logic               sgn1;
    logic               sgn2;
    logic               neg_in;
    logic               fast_div0;
    logic               fast_ovf;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH-1:0]   fix_result;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_borrow;

    assign op_in = muldiv_op_t'(op);

    always_comb begin
        is_mul_in = ~op[2];
        sgn1      = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                    (op_in == OP_DIV)  || (op_in == OP_REM);
        sgn2      = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        mag1      = (sgn1 && arg1[WIDTH-1]) ? -arg1 : arg1;
        mag2      = (sgn2 && arg2[WIDTH-1]) ? -arg2 : arg2;
        case (op_in)
            OP_MULH:   neg_in = arg1[WIDTH-1] ^ arg2[WIDTH-1];
            OP_MULHSU: neg_in = arg1[WIDTH-1];
            OP_DIV:    neg_in = arg1[WIDTH-1] ^ arg2[WIDTH-1];
            OP_REM:    neg_in = arg1[WIDTH-1];
            default:   neg_in = 1'b0;
        endcase
        fast_div0 = op[2] && (arg2 == '0);
        fast_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (arg1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&arg2);
    end

    // One datapath step: multiply adds into the high half then shifts right;
    // divide shifts the dividend MSB into the remainder and trial-subtracts.
    always_comb begin
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff   = div_shift - {1'b0, opnd};
        div_borrow = div_shift < {1'b0, opnd};
        if (op_q[2]) begin
            acc_step = {(div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                        acc[WIDTH-2:0], ~div_borrow};
        end else if (acc[0]) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    accept    = 1'b1;
                    state_nxt = (fast_div0 || fast_ovf) ? FIX : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = flush ? IDLE : DONE;
            end
            DONE: begin
                // busy is already low here, so a back-to-back start is taken
                done      = 1'b1;
                state_nxt = IDLE;
                if (start && !flush) begin
                    accept    = 1'b1;
                    state_nxt = (fast_div0 || fast_ovf) ? FIX : CALC;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= OP_MUL;
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            neg_q <= 1'b0;
            out   <= '0;
        end else begin
            if (accept) begin
                op_q <= op_in;
                cnt  <= CNT_W'(STEPS - 1);
                // Fast-path results are preloaded so FIX selects them unchanged
                if (fast_div0) begin
                    acc   <= {arg1, {WIDTH{1'b1}}};
                    opnd  <= '0;
                    neg_q <= 1'b0;
                end else if (fast_ovf) begin
                    acc   <= {{WIDTH{1'b0}}, arg1};
                    opnd  <= '0;
                    neg_q <= 1'b0;
                end else begin
                    acc   <= {{WIDTH{1'b0}}, (is_mul_in ? mag2 : mag1)};
                    opnd  <= is_mul_in ? mag1 : mag2;
                    neg_q <= neg_in;
                end
            end else if ((state == CALC) && !flush) begin
                acc <= acc_step;
                cnt <= cnt - CNT_W'(1);
            end
            if ((state == FIX) && !flush) begin
                out <= fix_result;
            end
        end
    end

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .op     (op_q),
        .neg    (neg_q),
        .acc    (acc),
        .result (fix_result)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus flush/reset/back-to-back sequences.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] arg1;
    logic [31:0] arg2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .arg1  (arg1),
        .arg2  (arg2),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic add_vec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e, input int l, input string n);
        vec_t v;
        v.op = o; v.a1 = a; v.a2 = b; v.exp = e; v.lat = l; v.name = n;
        vecs.push_back(v);
    endtask

    // Called right after the accepting posedge; returns at the negedge of the done cycle
    task automatic wait_done(output int lat, output logic [31:0] res, output logic busy_ok,
                             output logic busy_at_done);
        @(negedge clk);
        start   = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!done && lat < 60) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        res          = out;
        busy_at_done = busy;
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        arg1  = a;
        arg2  = b;
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        bok;
        logic        bdone;
        logic        seen_done;

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; arg1 = '0; arg2 = '0;

        add_vec(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_7_m3");
        add_vec(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_ff");
        add_vec(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, "mulh_ff");
        add_vec(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu_ff");
        add_vec(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh_min_min");
        add_vec(3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 34, "mulh_m2_3");
        add_vec(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div_m7_2");
        add_vec(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem_m7_2");
        add_vec(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, "div_7_m2");
        add_vec(3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34, "rem_7_m2");
        add_vec(3'b101, 32'd100,      32'd7,        32'd14,       34, "divu_100_7");
        add_vec(3'b111, 32'd100,      32'd7,        32'd2,        34, "remu_100_7");
        add_vec(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2,  "divu_by0");
        add_vec(3'b111, 32'd5,        32'd0,        32'd5,        2,  "remu_by0");
        add_vec(3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 2,  "div_by0");
        add_vec(3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 2,  "rem_by0");
        add_vec(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  "div_ovf");
        add_vec(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2,  "rem_ovf");

        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_out",  out, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a1, vecs[i].a2);
            @(posedge clk);
            wait_done(lat, res, bok, bdone);
            check({vecs[i].name, "_out"},  res, vecs[i].exp);
            check({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].lat));
            check({vecs[i].name, "_busy"}, {31'd0, bok}, 32'd1);
            check({vecs[i].name, "_busy_at_done"}, {31'd0, bdone}, 32'd0);
            @(negedge clk);
        end

        // flush and start together in IDLE: request dropped
        drive(3'b000, 32'd3, 32'd3);
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_drop", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // start while busy is ignored
        drive(3'b000, 32'd7, 32'hFFFFFFFD);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            if (lat == 5) drive(3'b000, 32'd3, 32'd3);
            if (lat == 6) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("ignore_out", out, 32'hFFFFFFEB);
        check("ignore_lat", 32'(lat), 32'd34);
        @(negedge clk);

        // flush at cycle 10 of a MUL
        drive(3'b000, 32'd11, 32'd13);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_out_kept", out, 32'hFFFFFFEB);
        seen_done = 1'b0;
        repeat (40) begin
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        check("flush_no_done", {31'd0, seen_done}, 32'd0);

        drive(3'b101, 32'd9, 32'd3);
        @(posedge clk);
        wait_done(lat, res, bok, bdone);
        check("divu_9_3_out", res, 32'd3);
        check("divu_9_3_lat", 32'(lat), 32'd34);
        @(negedge clk);

        // reset at cycle 20 of a DIV
        drive(3'b100, 32'hFFFFFFF9, 32'd2);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_out",  out, 32'd0);
        @(negedge clk);

        // back-to-back: start in the DONE cycle of MUL 2x3
        drive(3'b000, 32'd2, 32'd3);
        @(posedge clk);
        wait_done(lat, res, bok, bdone);
        check("b2b_first_out", res, 32'd6);
        check("b2b_first_lat", 32'(lat), 32'd34);
        drive(3'b000, 32'd4, 32'd5);
        @(posedge clk);
        wait_done(lat, res, bok, bdone);
        check("b2b_second_out", res, 32'd20);
        check("b2b_second_lat", 32'(lat), 32'd34);
        check("b2b_second_busy", {31'd0, bok}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
